// File: rtl/input_pkg.sv
// Shared types for the button input path: repeat-FSM states and the key-event
// record consumed by the downstream input decoder.
package input_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } state_t;

  // Index field is sized for the widest button bank the decoder accepts.
  localparam int EVT_IDX_W = 8;

  typedef struct packed {
    logic                 valid;
    logic [EVT_IDX_W-1:0] idx;
    logic                 is_repeat;
  } key_evt_t;

endpackage

// File: rtl/lowest_set_index.sv
// Combinational priority encoder: index of the lowest set bit of vec, plus a
// flag telling whether any bit is set at all.
module lowest_set_index #(
  parameter int N = 5,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic         any
);

  always_comb begin
    idx = '0;
    any = |vec;
    // Scan downward so the lowest set bit is the last to write idx.
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) idx = W'(i);
    end
  end

endmodule

// File: rtl/button_repeat.sv
// Keyboard-style auto-repeat: one press event per rising button, then periodic
// repeat events for the most recently pressed button while it stays held.
//
// state  | meaning
// IDLE   | no button tracked, waiting for a press
// DELAY  | active button held, counting down the hold delay
// REPEAT | active button held, counting down the repeat interval
module button_repeat #(
  parameter int N           = 5,
  parameter int DELAY_TICKS = 1000,
  parameter int RATE_TICKS  = 100
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic [N-1:0]         btn,
  output logic                 evt_valid,
  output logic [$clog2(N)-1:0] evt_idx,
  output logic                 evt_repeat,
  output logic                 held
);
  import input_pkg::*;

  localparam int IW        = $clog2(N);
  localparam int MAX_TICKS = (DELAY_TICKS > RATE_TICKS) ? DELAY_TICKS : RATE_TICKS;
  localparam int CW        = $clog2(MAX_TICKS + 1);

  logic [N-1:0]  btn_q;
  logic [N-1:0]  rise;
  logic [IW-1:0] rise_idx;
  logic          rise_any;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [IW-1:0] active, active_n;
  logic          evt_valid_n;
  logic [IW-1:0] evt_idx_n;
  logic          evt_repeat_n;

  assign rise = btn & ~btn_q;

  lowest_set_index #(
    .N (N),
    .W (IW)
  ) u_rise_enc (
    .vec (rise),
    .idx (rise_idx),
    .any (rise_any)
  );

  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    active_n     = active;
    evt_valid_n  = 1'b0;
    evt_idx_n    = '0;
    evt_repeat_n = 1'b0;

    if (rise_any) begin
      // A new press always wins: over a release of active and over a tick.
      active_n    = rise_idx;
      evt_valid_n = 1'b1;
      evt_idx_n   = rise_idx;
      cnt_n       = CW'(DELAY_TICKS);
      state_n     = DELAY;
    end else if (state != IDLE && !btn[active]) begin
      state_n = IDLE;
    end else if (state != IDLE && tick) begin
      if (cnt == CW'(1)) begin
        evt_valid_n  = 1'b1;
        evt_idx_n    = active;
        evt_repeat_n = 1'b1;
        cnt_n        = CW'(RATE_TICKS);
        state_n      = REPEAT;
      end else begin
        cnt_n = cnt - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_q      <= '1;
      state      <= IDLE;
      cnt        <= '0;
      active     <= '0;
      evt_valid  <= 1'b0;
      evt_idx    <= '0;
      evt_repeat <= 1'b0;
    end else begin
      btn_q      <= btn;
      state      <= state_n;
      cnt        <= cnt_n;
      active     <= active_n;
      evt_valid  <= evt_valid_n;
      evt_idx    <= evt_idx_n;
      evt_repeat <= evt_repeat_n;
    end
  end

  assign held = (state != IDLE);

endmodule

// File: tb/tb_button_repeat.sv
// Scoreboard bench for button_repeat: expected events are queued with the
// clock edge they must appear on, then matched as the DUT emits them.
module tb_button_repeat;

  localparam int N  = 5;
  localparam int DT = 3;
  localparam int RT = 2;

  logic       clk;
  logic       rst;
  logic       tick;
  logic [4:0] btn;
  logic       evt_valid;
  logic [2:0] evt_idx;
  logic       evt_repeat;
  logic       held;

  button_repeat #(
    .N           (N),
    .DELAY_TICKS (DT),
    .RATE_TICKS  (RT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .btn        (btn),
    .evt_valid  (evt_valid),
    .evt_idx    (evt_idx),
    .evt_repeat (evt_repeat),
    .held       (held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int idx;
    int rpt;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (edge %0d)", tag, obs, exp, cyc);
  endtask

  // Edge k carries a tick iff k % 4 == 0; returns the edge of the n-th tick after e.
  function automatic int nth_tick_after(input int e, input int n);
    int t = e;
    int c = 0;
    while (c < n) begin
      t++;
      if (t % 4 == 0) c++;
    end
    return t;
  endfunction

  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (evt_valid) begin
      if (sb.size() == 0) begin
        chk("evt_unexpected", int'(evt_idx), -1);
      end else begin
        e = sb.pop_front();
        chk("evt_cyc", cyc, e.cyc);
        chk("evt_idx", int'(evt_idx), e.idx);
        chk("evt_rpt", int'(evt_repeat), e.rpt);
      end
    end else begin
      chk("evt_fields_zero", int'({evt_idx, evt_repeat}), 0);
      if (sb.size() > 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        chk($sformatf("evt_missing_idx%0d", e.idx), cyc, e.cyc - 1);
      end
    end
    tick = ((cyc + 1) % 4 == 0);
  endtask

  // Drive b for the next edge p, expect a press of idx there and repeats while
  // held; returns at edge p+hold-1 so the caller drives the value seen at p+hold.
  task automatic press(input logic [4:0] b, input int idx, input int hold);
    int p, r;
    p = cyc + 1;
    btn = b;
    sb.push_back('{p, idx, 0});
    r = nth_tick_after(p, DT);
    while (r < p + hold) begin
      sb.push_back('{r, idx, 1});
      r = nth_tick_after(r, RT);
    end
    step();
    chk("held_after_press", int'(held), 1);
    while (cyc < p + hold - 1) step();
  endtask

  task automatic release_to(input logic [4:0] b, input int quiet);
    btn = b;
    step();
    repeat (quiet) step();
    chk("held_after_release", int'(held), 0);
  endtask

  initial begin
    rst  = 1'b1;
    tick = 1'b0;
    btn  = 5'b00100;

    // Button held through reset must stay silent.
    repeat (3) step();
    chk("rst_evt_valid", int'(evt_valid), 0);
    chk("rst_held", int'(held), 0);
    rst = 1'b0;
    repeat (40) step();
    chk("held_btn_no_track", int'(held), 0);
    release_to(5'b00000, 3);
    press(5'b00100, 2, 5);
    release_to(5'b00000, 4);

    // Press and hold for 30 ticks.
    press(5'b00010, 1, 120);
    release_to(5'b00000, 10);

    // Simultaneous press picks the lowest index.
    press(5'b10010, 1, 30);
    release_to(5'b00000, 5);

    // Preempt: idx 0 into REPEAT, then idx 4 takes over.
    press(5'b00001, 0, 24);
    press(5'b10001, 4, 20);
    release_to(5'b00000, 5);

    // Releasing the active button drops to IDLE even with another held.
    press(5'b00001, 0, 8);
    press(5'b01001, 3, 10);
    release_to(5'b00001, 20);
    release_to(5'b00000, 3);

    // Release of active and press of another in the same cycle.
    press(5'b00001, 0, 10);
    press(5'b00100, 2, 14);
    release_to(5'b00000, 5);

    // Press on a tick edge: that tick does not count toward the delay.
    while ((cyc + 1) % 4 != 0) step();
    press(5'b00010, 1, 20);
    release_to(5'b00000, 5);

    // Reset mid-delay abandons the count.
    press(5'b00010, 1, 3);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_mid_valid", int'(evt_valid), 0);
    chk("rst_mid_held", int'(held), 0);
    step();
    step();
    rst = 1'b0;
    repeat (20) step();
    chk("rst_mid_stays_idle", int'(held), 0);
    release_to(5'b00000, 3);

    chk("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
